// File: rtl/jump_resolver.sv
// EX-stage jump resolver: checks each IF prediction against the EX outcome, issues
// a registered flush/redirect on a mispredict and streams gshare update records.
module jump_resolver #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CW           = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          valid_in,
   input  logic          ready_in,
   input  logic [31:0]   PC_EX,
   input  logic          jump_ena_EX,
   input  logic          jump_alw_EX,
   input  logic          jump_taken_EX,
   input  logic [31:0]   jump_addr_EX,
   input  logic          jump_pred_EX,
   input  logic [31:0]   pred_addr_EX,
   output logic          flush,
   output logic [31:0]   redirect_addr,
   output logic          upd_valid,
   output logic [31:0]   upd_PC,
   output logic          upd_taken,
   output logic [CW-1:0] branch_cnt,
   output logic [CW-1:0] mispred_cnt
);

   typedef enum logic {IDLE, FLUSH} state_t;

   localparam logic [3:0]    FLUSH_LOAD = 4'(FLUSH_CYCLES);
   localparam logic [CW-1:0] CNT_MAX    = '1;

   state_t      state, next_state;
   logic [3:0]  supp_cnt, supp_next;
   logic        resolve, taken_act, mispredict, do_update;
   logic [31:0] correct_addr;

   assign resolve      = valid_in && ready_in && jump_ena_EX && (state == IDLE);
   assign taken_act    = jump_alw_EX | jump_taken_EX;
   assign mispredict   = resolve && ((taken_act != jump_pred_EX) ||
                         (taken_act && jump_pred_EX && (pred_addr_EX != jump_addr_EX)));
   assign do_update    = resolve && !jump_alw_EX;
   assign correct_addr = taken_act ? jump_addr_EX : PC_EX + 32'd4;

   // Wrong-path window only shrinks on cycles where EX actually advances
   always_comb begin
      next_state = state;
      supp_next  = supp_cnt;
      case (state)
         IDLE: begin
            if (mispredict) begin
               next_state = FLUSH;
               supp_next  = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (ready_in) begin
               supp_next = supp_cnt - 4'd1;
               if (supp_cnt <= 4'd1) begin
                  next_state = IDLE;
                  supp_next  = 4'd0;
               end
            end
         end
         default: begin
            next_state = IDLE;
            supp_next  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         supp_cnt <= 4'd0;
      end else begin
         state    <= next_state;
         supp_cnt <= supp_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flush         <= 1'b0;
         redirect_addr <= 32'd0;
         upd_valid     <= 1'b0;
         upd_PC        <= 32'd0;
         upd_taken     <= 1'b0;
      end else begin
         flush     <= mispredict;
         upd_valid <= do_update;
         upd_PC    <= do_update ? PC_EX : 32'd0;
         upd_taken <= do_update ? jump_taken_EX : 1'b0;
         if (mispredict) begin
            redirect_addr <= correct_addr;
         end
      end
   end

   // Performance counters stick at all-ones instead of wrapping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (do_update && (branch_cnt != CNT_MAX)) begin
            branch_cnt <= branch_cnt + 1'b1;
         end
         if (mispredict && (mispred_cnt != CNT_MAX)) begin
            mispred_cnt <= mispred_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_jump_resolver.sv
// Directed bench for jump_resolver: per-cycle vector table plus hand-written
// saturation and reset-during-flush sequences, with a narrow CW to reach saturation.
module tb_jump_resolver;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   typedef struct {
      logic        valid;
      logic        ready;
      logic [31:0] pc;
      logic        ena;
      logic        alw;
      logic        taken;
      logic [31:0] addr;
      logic        pred;
      logic [31:0] paddr;
      logic        e_flush;
      logic [31:0] e_redir;
      logic        e_uv;
      logic [31:0] e_upc;
      logic        e_ut;
      logic [3:0]  e_bc;
      logic [3:0]  e_mc;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic        valid_in, ready_in, jump_ena_EX, jump_alw_EX, jump_taken_EX, jump_pred_EX;
   logic [31:0] PC_EX, jump_addr_EX, pred_addr_EX;
   logic        flush, upd_valid, upd_taken;
   logic [31:0] redirect_addr, upd_PC;
   logic [3:0]  branch_cnt, mispred_cnt;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   jump_resolver #(.FLUSH_CYCLES(2), .CW(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .valid_in     (valid_in),
      .ready_in     (ready_in),
      .PC_EX        (PC_EX),
      .jump_ena_EX  (jump_ena_EX),
      .jump_alw_EX  (jump_alw_EX),
      .jump_taken_EX(jump_taken_EX),
      .jump_addr_EX (jump_addr_EX),
      .jump_pred_EX (jump_pred_EX),
      .pred_addr_EX (pred_addr_EX),
      .flush        (flush),
      .redirect_addr(redirect_addr),
      .upd_valid    (upd_valid),
      .upd_PC       (upd_PC),
      .upd_taken    (upd_taken),
      .branch_cnt   (branch_cnt),
      .mispred_cnt  (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic v, input logic r, input logic [31:0] pc, input logic en,
      input logic al, input logic tk, input logic [31:0] ad, input logic pr,
      input logic [31:0] pa, input logic ef, input logic [31:0] er, input logic eu,
      input logic [31:0] ep, input logic et, input logic [3:0] eb, input logic [3:0] em);
      vec_t x;
      x.valid = v;   x.ready = r;   x.pc = pc;     x.ena = en;
      x.alw = al;    x.taken = tk;  x.addr = ad;   x.pred = pr;
      x.paddr = pa;  x.e_flush = ef; x.e_redir = er; x.e_uv = eu;
      x.e_upc = ep;  x.e_ut = et;   x.e_bc = eb;   x.e_mc = em;
      return x;
   endfunction

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      valid_in      = v.valid;
      ready_in      = v.ready;
      PC_EX         = v.pc;
      jump_ena_EX   = v.ena;
      jump_alw_EX   = v.alw;
      jump_taken_EX = v.taken;
      jump_addr_EX  = v.addr;
      jump_pred_EX  = v.pred;
      pred_addr_EX  = v.paddr;
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      check1({tag, " flush"}, 32'(flush), 32'(v.e_flush));
      check1({tag, " redirect_addr"}, redirect_addr, v.e_redir);
      check1({tag, " upd_valid"}, 32'(upd_valid), 32'(v.e_uv));
      if (v.e_uv) begin
         check1({tag, " upd_PC"}, upd_PC, v.e_upc);
         check1({tag, " upd_taken"}, 32'(upd_taken), 32'(v.e_ut));
      end
      check1({tag, " branch_cnt"}, 32'(branch_cnt), 32'(v.e_bc));
      check1({tag, " mispred_cnt"}, 32'(mispred_cnt), 32'(v.e_mc));
   endtask

   task automatic stepCheck(input vec_t v, input string tag);
      applyStimulus(v);
      @(negedge clk);
      checkOutput(v, tag);
   endtask

   initial begin
      vec_t v;
      vec_t idle_v;

      // valid ready pc ena alw taken addr pred paddr | flush redir uv upc ut bc mc
      vecs.push_back(mk(F,F,32'h0,F,F,F,32'h0,F,32'h0,  F,32'h0,F,32'h0,F,4'd0,4'd0));
      vecs.push_back(mk(T,T,32'h100,T,F,F,32'h0,F,32'h0,  F,32'h0,T,32'h100,F,4'd1,4'd0));
      vecs.push_back(mk(F,T,32'h0,F,F,F,32'h0,F,32'h0,  F,32'h0,F,32'h0,F,4'd1,4'd0));
      vecs.push_back(mk(T,T,32'h200,T,F,T,32'h180,F,32'h0,  T,32'h180,T,32'h200,T,4'd2,4'd1));
      vecs.push_back(mk(T,T,32'h300,T,F,T,32'h700,F,32'h0,  F,32'h180,F,32'h0,F,4'd2,4'd1));
      vecs.push_back(mk(T,T,32'h300,T,F,T,32'h700,F,32'h0,  F,32'h180,F,32'h0,F,4'd2,4'd1));
      vecs.push_back(mk(T,T,32'h300,T,F,T,32'h700,T,32'h700,  F,32'h180,T,32'h300,T,4'd3,4'd1));
      vecs.push_back(mk(T,F,32'h340,T,F,T,32'h740,F,32'h0,  F,32'h180,F,32'h0,F,4'd3,4'd1));
      vecs.push_back(mk(T,T,32'h380,F,F,F,32'h0,T,32'h780,  F,32'h180,F,32'h0,F,4'd3,4'd1));
      vecs.push_back(mk(T,T,32'h400,T,F,F,32'h0,F,32'h0,  F,32'h180,T,32'h400,F,4'd4,4'd1));
      vecs.push_back(mk(T,T,32'h404,T,F,T,32'h800,T,32'h800,  F,32'h180,T,32'h404,T,4'd5,4'd1));
      vecs.push_back(mk(T,T,32'hFFFFFFFC,T,F,F,32'h10,T,32'h10,  T,32'h0,T,32'hFFFFFFFC,F,4'd6,4'd2));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(T,F,32'h500,T,F,T,32'h520,F,32'h0,  F,32'h0,F,32'h0,F,4'd6,4'd2));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(T,T,32'h500,T,F,T,32'h520,F,32'h0,  F,32'h0,F,32'h0,F,4'd6,4'd2));
      vecs.push_back(mk(T,T,32'h500,T,F,T,32'h520,F,32'h0,  T,32'h520,T,32'h500,T,4'd7,4'd3));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(F,T,32'h0,F,F,F,32'h0,F,32'h0,  F,32'h520,F,32'h0,F,4'd7,4'd3));
      vecs.push_back(mk(T,T,32'h600,T,T,F,32'h400,F,32'h0,  T,32'h400,F,32'h0,F,4'd7,4'd4));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(F,T,32'h0,F,F,F,32'h0,F,32'h0,  F,32'h400,F,32'h0,F,4'd7,4'd4));
      vecs.push_back(mk(T,T,32'h700,T,T,F,32'h504,T,32'h500,  T,32'h504,F,32'h0,F,4'd7,4'd5));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(F,T,32'h0,F,F,F,32'h0,F,32'h0,  F,32'h504,F,32'h0,F,4'd7,4'd5));
      vecs.push_back(mk(T,T,32'h800,T,T,T,32'h900,T,32'h900,  F,32'h504,F,32'h0,F,4'd7,4'd5));

      reset_n = 1'b0;
      applyStimulus(vecs[0]);
      #12;
      checkOutput(vecs[0], "reset");
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         stepCheck(vecs[i], $sformatf("vec%0d", i));
      end

      // Mispredicting conditional branches drive both counters into saturation
      for (int i = 0; i < 12; i++) begin
         v = mk(T,T,32'h1000 + 32'(i*4),T,F,T,32'h2000,F,32'h0,
                T,32'h2000,T,32'h1000 + 32'(i*4),T,
                4'((8 + i > 15) ? 15 : 8 + i), 4'((6 + i > 15) ? 15 : 6 + i));
         stepCheck(v, $sformatf("sat%0d", i));
         idle_v = mk(F,T,32'h0,F,F,F,32'h0,F,32'h0,  F,32'h2000,F,32'h0,F,v.e_bc,v.e_mc);
         stepCheck(idle_v, $sformatf("sat%0d_idle0", i));
         stepCheck(idle_v, $sformatf("sat%0d_idle1", i));
      end

      // Reset lands while the resolver is in FLUSH
      v = mk(T,T,32'h3000,T,F,T,32'h3400,F,32'h0,  T,32'h3400,T,32'h3000,T,4'd15,4'd15);
      stepCheck(v, "pre_reset");
      reset_n = 1'b0;
      #1;
      v = mk(F,F,32'h0,F,F,F,32'h0,F,32'h0,  F,32'h0,F,32'h0,F,4'd0,4'd0);
      applyStimulus(v);
      checkOutput(v, "midflush_reset");
      check1("midflush_reset upd_PC", upd_PC, 32'h0);
      check1("midflush_reset upd_taken", 32'(upd_taken), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      stepCheck(mk(T,T,32'h3100,T,F,F,32'h0,F,32'h0,  F,32'h0,T,32'h3100,F,4'd1,4'd0), "post_reset");
      stepCheck(mk(F,T,32'h0,F,F,F,32'h0,F,32'h0,  F,32'h0,F,32'h0,F,4'd1,4'd0), "post_reset_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jump_resolver.md
Name: jump_resolver

Overview:
- EX-stage counterpart of the IF-stage gshare predictor.
- Compares each jump's IF prediction (carried down the pipeline) with its EX outcome and target.
- On a mispredict, issues a registered flush/redirect to the fetch unit and suppresses resolution of the wrong-path instructions still in flight.
- Produces the registered predictor update stream for conditional branches, plus saturating branch and mispredict counters.

Parameters:
FLUSH_CYCLES, 2, number of advancing EX cycles after a flush during which instructions are treated as wrong-path (1..15)
CW, 32, width of the performance counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  EX stage holds a valid instruction
ready_in  in  1  EX stage advances this cycle
PC_EX  in  32  PC of the EX instruction
jump_ena_EX  in  1  instruction is a jump/branch/trap return
jump_alw_EX  in  1  unconditional jump (JAL/JALR/MRET)
jump_taken_EX  in  1  conditional branch outcome
jump_addr_EX  in  32  actual target computed in EX
jump_pred_EX  in  1  IF prediction (taken) carried to EX
pred_addr_EX  in  32  IF predicted target carried to EX
flush  out  1  squash IF/ID and redirect fetch (one-cycle pulse)
redirect_addr  out  32  fetch restart address, valid while flush=1
upd_valid  out  1  predictor update strobe (one-cycle pulse)
upd_PC  out  32  PC of the resolved conditional branch
upd_taken  out  1  outcome of the resolved conditional branch
branch_cnt  out  CW  resolved conditional branches
mispred_cnt  out  CW  mispredicted jumps

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, suppress counter=0.
  - flush=0, redirect_addr=0, upd_valid=0, upd_PC=0, upd_taken=0, branch_cnt=0, mispred_cnt=0.
  - Reset asserted mid-FLUSH aborts the flush immediately.
- resolve = valid_in && ready_in && jump_ena_EX && state==IDLE.
- taken_act = jump_alw_EX | jump_taken_EX. This is a logical OR: jump_taken_EX is ignored when jump_alw_EX=1.
- Mispredict when resolve is true and either:
  - taken_act != jump_pred_EX, or
  - taken_act && jump_pred_EX && pred_addr_EX != jump_addr_EX.
- Correct address = taken_act ? jump_addr_EX : PC_EX + 4, with 32-bit wrap-around (0xFFFFFFFC+4 = 0).
- Latency is 1 cycle. On the edge where the mispredict is sampled: flush<=1 and redirect_addr<=correct address. Both are visible the following cycle. flush drops the cycle after.
- redirect_addr holds its last value while flush=0.
- Predictor update:
  - When resolve && !jump_alw_EX: upd_valid<=1, upd_PC<=PC_EX, upd_taken<=jump_taken_EX, all for one cycle.
  - The update is issued whether or not the branch mispredicted.
  - Unconditional jumps never generate an update.
- Counters, both saturating at 2^CW-1 (no wrap):
  - branch_cnt += 1 on each update.
  - mispred_cnt += 1 on each mispredict.
- State machine:
  - IDLE -> FLUSH on a mispredict. Suppress counter loads FLUSH_CYCLES.
  - In FLUSH, the counter decrements on each cycle with ready_in=1. It holds when ready_in=0.
  - FLUSH -> IDLE when the counter reaches 0.
  - No resolution, update, counter increment or new flush occurs in FLUSH, regardless of valid_in or jump_ena_EX.
- ready_in=0 in IDLE: no resolution. Registered outputs still fall back to 0 after their one-cycle pulse.
- jump_ena_EX=0: no action, even if jump_pred_EX=1.
- Back-to-back resolving branches in IDLE with no mispredict: one update per cycle, no bubbles.

Test Plan:
1. Reset then idle: all outputs 0. Release reset_n with no valid_in -> outputs stay 0, state IDLE.
2. Correct not-taken branch: PC_EX=0x100, jump_taken_EX=0, jump_pred_EX=0 -> next cycle upd_valid=1, upd_PC=0x100, upd_taken=0, flush=0, branch_cnt=1, mispred_cnt=0.
3. Taken branch predicted not-taken: PC_EX=0x200, jump_addr_EX=0x180, pred=0 -> next cycle flush=1, redirect_addr=0x180, upd_taken=1, mispred_cnt=1. The next 2 advancing cycles carry a valid taken branch that must be ignored. The third advancing branch resolves normally.
4. Predicted taken, not taken at PC_EX=0xFFFFFFFC -> flush=1, redirect_addr=0x00000000. FLUSH holds while ready_in=0 for 5 cycles, then completes after 2 ready cycles.
5. JALR: jump_alw_EX=1, pred=0, jump_addr_EX=0x400 -> flush=1, redirect_addr=0x400, upd_valid=0, branch_cnt unchanged. MRET: pred=1, pred_addr_EX=0x500, jump_addr_EX=0x504 -> flush=1, redirect_addr=0x504.
6. Saturation and reset: with CW=4, 17 mispredicts -> mispred_cnt=15. Assert reset_n=0 during FLUSH -> all outputs 0 immediately, and the next branch resolves in IDLE.
